mem_ctrl: RTL and testbench

//   Upstream memory port of the RV32I core. Serialises instruction-fetch and load/store requests onto the 8-bit RAM/IO bus.

---
 rtl/mem_ctrl_if.sv | 38 +++
 rtl/mem_ctrl.sv | 159 +++++++++++++++
 tb/tb_mem_ctrl.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_if.sv
// Core-side request/response and RAM/IO bus signals of the memory controller.
// The controller is the bus master toward RAM/IO and takes the master modport;
// the surrounding core/RAM environment takes the slave modport.
interface mem_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              rdy_in;
  // fetch port
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_data;
  logic              if_done;
  // load/store port
  logic              ls_req;
  logic              ls_we;
  logic [1:0]        ls_len;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic [DATA_W-1:0] ls_rdata;
  logic              ls_done;
  // RAM/IO byte bus
  logic [7:0]        mem_din;
  logic [7:0]        mem_dout;
  logic [ADDR_W-1:0] mem_a;
  logic              mem_wr;
  logic              busy;

  modport master (
    input  rdy_in, if_req, if_addr, ls_req, ls_we, ls_len, ls_addr, ls_wdata, mem_din,
    output if_data, if_done, ls_rdata, ls_done, mem_dout, mem_a, mem_wr, busy
  );

  modport slave (
    output rdy_in, if_req, if_addr, ls_req, ls_we, ls_len, ls_addr, ls_wdata, mem_din,
    input  if_data, if_done, ls_rdata, ls_done, mem_dout, mem_a, mem_wr, busy
  );
endinterface

// File: rtl/mem_ctrl.sv
// Memory controller: serialises instruction fetches and loads/stores onto an
// 8-bit RAM/IO bus and assembles little-endian bytes into 32-bit words.
// Reads: address byte k in cycle k+1, capture it one cycle later.
// Writes: one byte per cycle. rdy_in=0 freezes every register.
module mem_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic       clk,
  input  logic       rst,
  mem_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state;
  logic [2:0]        cnt;        // cycles spent in RD, or byte index in WR
  logic [2:0]        nbytes;     // 1, 2 or 4
  logic [ADDR_W-1:0] addr;       // latched base address
  logic [DATA_W-1:0] wdata;      // latched store data
  logic [DATA_W-1:0] cap;        // read bytes captured so far
  logic              is_fetch;   // current access belongs to the fetch port

  logic [2:0]        next_off;
  logic [ADDR_W-1:0] next_addr;
  logic [1:0]        cap_idx;
  logic [DATA_W-1:0] rd_word;

  // Access size in bytes; the reserved length code behaves as a word.
  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    case (len)
      2'b00:   len_bytes = 3'd1;
      2'b01:   len_bytes = 3'd2;
      default: len_bytes = 3'd4;
    endcase
  endfunction

  // Little-endian byte k of a data word.
  function automatic logic [7:0] byte_sel(input logic [DATA_W-1:0] w, input logic [1:0] k);
    byte_sel = w[{k, 3'b000} +: 8];
  endfunction

  // Next byte address, and the capture word with the byte arriving on mem_din merged in.
  always_comb begin
    next_off  = cnt + 3'd1;
    next_addr = addr + {{(ADDR_W-3){1'b0}}, next_off};
    cap_idx   = cnt[1:0] - 2'd1;
    rd_word   = cap;
    rd_word[{cap_idx, 3'b000} +: 8] = bus.mem_din;
  end

  // Access FSM with registered bus and response outputs; rdy_in low holds everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= 3'd0;
      nbytes       <= 3'd0;
      addr         <= {ADDR_W{1'b0}};
      wdata        <= {DATA_W{1'b0}};
      cap          <= {DATA_W{1'b0}};
      is_fetch     <= 1'b0;
      bus.if_data  <= {DATA_W{1'b0}};
      bus.if_done  <= 1'b0;
      bus.ls_rdata <= {DATA_W{1'b0}};
      bus.ls_done  <= 1'b0;
      bus.mem_dout <= 8'h00;
      bus.mem_a    <= {ADDR_W{1'b0}};
      bus.mem_wr   <= 1'b0;
      bus.busy     <= 1'b0;
    end else if (bus.rdy_in) begin
      case (state)
        IDLE: begin
          cnt <= 3'd0;
          cap <= {DATA_W{1'b0}};
          if (bus.ls_req) begin
            // data side wins arbitration; a waiting fetch is taken next IDLE
            addr      <= bus.ls_addr;
            bus.mem_a <= bus.ls_addr;
            nbytes    <= len_bytes(bus.ls_len);
            is_fetch  <= 1'b0;
            bus.busy  <= 1'b1;
            if (bus.ls_we) begin
              wdata        <= bus.ls_wdata;
              bus.mem_dout <= byte_sel(bus.ls_wdata, 2'd0);
              bus.mem_wr   <= 1'b1;
              state        <= WR;
            end else begin
              bus.mem_wr <= 1'b0;
              state      <= RD;
            end
          end else if (bus.if_req) begin
            addr       <= bus.if_addr;
            bus.mem_a  <= bus.if_addr;
            nbytes     <= 3'd4;
            is_fetch   <= 1'b1;
            bus.busy   <= 1'b1;
            bus.mem_wr <= 1'b0;
            state      <= RD;
          end else begin
            bus.mem_wr <= 1'b0;
            state      <= IDLE;
          end
        end

        RD: begin
          // capture lags addressing by one cycle, so the first RD cycle has nothing to take
          cnt <= next_off;
          if (cnt != 3'd0) begin
            cap <= rd_word;
          end
          // only requested bytes are addressed; mem_a holds on the last one
          if (next_off < nbytes) begin
            bus.mem_a <= next_addr;
          end
          if (cnt == nbytes) begin
            state <= DONE;
            if (is_fetch) begin
              bus.if_data <= rd_word;
              bus.if_done <= 1'b1;
            end else begin
              bus.ls_rdata <= rd_word;
              bus.ls_done  <= 1'b1;
            end
          end
        end

        WR: begin
          if (next_off == nbytes) begin
            bus.mem_wr  <= 1'b0;
            bus.ls_done <= 1'b1;
            state       <= DONE;
          end else begin
            cnt          <= next_off;
            bus.mem_a    <= next_addr;
            bus.mem_dout <= byte_sel(wdata, next_off[1:0]);
          end
        end

        DONE: begin
          bus.if_done <= 1'b0;
          bus.ls_done <= 1'b0;
          bus.busy    <= 1'b0;
          cnt         <= 3'd0;
          state       <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: byte-wide RAM model whose read port shares the
// rdy_in stall, hand-computed addresses, data and completion cycles.
module tb_mem_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;
  logic [7:0] ram [logic [31:0]];

  mem_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  mem_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    if (ram.exists(a)) return ram[a];
    else return 8'h00;
  endfunction

  // RAM: registered 1-cycle read data, write on mem_wr; both stall with rdy_in
  always @(posedge clk) begin
    if (bus.rdy_in) begin
      bus.mem_din <= ram_rd(bus.mem_a);
      if (bus.mem_wr) ram[bus.mem_a] = bus.mem_dout;
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic skip(input int n);
    for (int i = 0; i < n; i++) nxt();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    ram[32'h1000] = 8'h13; ram[32'h1001] = 8'h05; ram[32'h1002] = 8'h00; ram[32'h1003] = 8'h00;
    ram[32'h1004] = 8'h93; ram[32'h1005] = 8'h00; ram[32'h1006] = 8'h10; ram[32'h1007] = 8'h00;
    ram[32'h2002] = 8'hFF; ram[32'h2003] = 8'h80;
    rst = 1'b0;
    bus.rdy_in = 1'b1;
    bus.if_req = 1'b0; bus.if_addr = 32'h0;
    bus.ls_req = 1'b0; bus.ls_we = 1'b0; bus.ls_len = 2'b00;
    bus.ls_addr = 32'h0; bus.ls_wdata = 32'h0;

    // reset state
    skip(2);
    check("rst_mem_a", bus.mem_a, 32'h0);
    check("rst_mem_wr", {31'd0, bus.mem_wr}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_if_data", bus.if_data, 32'h0);
    rst = 1'b1;
    skip(2);

    // 1: word fetch at 0x1000
    bus.if_addr = 32'h1000; bus.if_req = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      nxt();
      if (c <= 4) check("t1_mem_a", bus.mem_a, 32'h1000 + 32'(c - 1));
      check("t1_mem_wr", {31'd0, bus.mem_wr}, 32'd0);
      check("t1_early_done", {31'd0, bus.if_done}, 32'd0);
    end
    nxt();
    check("t1_done", {31'd0, bus.if_done}, 32'd1);
    check("t1_if_data", bus.if_data, 32'h00000513);
    bus.if_req = 1'b0;
    nxt();
    check("t1_done_pulse", {31'd0, bus.if_done}, 32'd0);
    check("t1_idle", {31'd0, bus.busy}, 32'd0);

    // 2: byte store 0xAB at 0x30000
    bus.ls_we = 1'b1; bus.ls_len = 2'b00; bus.ls_addr = 32'h30000; bus.ls_wdata = 32'h000000AB;
    bus.ls_req = 1'b1;
    nxt();
    check("t2_mem_wr", {31'd0, bus.mem_wr}, 32'd1);
    check("t2_mem_a", bus.mem_a, 32'h30000);
    check("t2_mem_dout", {24'd0, bus.mem_dout}, 32'hAB);
    check("t2_early_done", {31'd0, bus.ls_done}, 32'd0);
    nxt();
    check("t2_done", {31'd0, bus.ls_done}, 32'd1);
    check("t2_wr_low", {31'd0, bus.mem_wr}, 32'd0);
    bus.ls_req = 1'b0;
    nxt();
    check("t2_wr_after", {31'd0, bus.mem_wr}, 32'd0);
    check("t2_ram", {24'd0, ram_rd(32'h30000)}, 32'hAB);

    // 3: half load at 0x2002 and fetch at 0x1004 raised together
    bus.ls_we = 1'b0; bus.ls_len = 2'b01; bus.ls_addr = 32'h2002;
    bus.if_addr = 32'h1004;
    bus.ls_req = 1'b1; bus.if_req = 1'b1;
    nxt();
    check("t3_mem_a0", bus.mem_a, 32'h2002);
    nxt();
    check("t3_mem_a1", bus.mem_a, 32'h2003);
    nxt();
    check("t3_early_done", {31'd0, bus.ls_done}, 32'd0);
    nxt();
    check("t3_ls_done", {31'd0, bus.ls_done}, 32'd1);
    check("t3_ls_rdata", bus.ls_rdata, 32'h000080FF);
    check("t3_no_if_done", {31'd0, bus.if_done}, 32'd0);
    bus.ls_req = 1'b0;
    nxt();
    check("t3_idle", {31'd0, bus.busy}, 32'd0);
    nxt();
    check("t3_fetch_a", bus.mem_a, 32'h1004);
    check("t3_fetch_busy", {31'd0, bus.busy}, 32'd1);
    skip(4);
    check("t3_if_early", {31'd0, bus.if_done}, 32'd0);
    nxt();
    check("t3_if_done", {31'd0, bus.if_done}, 32'd1);
    check("t3_if_data", bus.if_data, 32'h00100093);
    bus.if_req = 1'b0;
    nxt();

    // 4: fetch at 0x1000 with rdy_in low in cycles 2..4
    bus.if_addr = 32'h1000; bus.if_req = 1'b1;
    nxt();
    check("t4_mem_a_c1", bus.mem_a, 32'h1000);
    for (int c = 2; c <= 5; c++) begin
      nxt();
      bus.rdy_in = (c == 5);
      check("t4_frozen_a", bus.mem_a, 32'h1001);
      check("t4_frozen_done", {31'd0, bus.if_done}, 32'd0);
    end
    nxt();
    check("t4_mem_a_c6", bus.mem_a, 32'h1002);
    nxt();
    check("t4_mem_a_c7", bus.mem_a, 32'h1003);
    nxt();
    check("t4_done_c8", {31'd0, bus.if_done}, 32'd0);
    nxt();
    check("t4_done_c9", {31'd0, bus.if_done}, 32'd1);
    check("t4_if_data", bus.if_data, 32'h00000513);
    bus.if_req = 1'b0;
    nxt();
    check("t4_done_c10", {31'd0, bus.if_done}, 32'd0);

    // 5: word store aborted by reset in cycle 2
    bus.ls_we = 1'b1; bus.ls_len = 2'b11; bus.ls_addr = 32'h100; bus.ls_wdata = 32'hDEADBEEF;
    bus.ls_req = 1'b1;
    nxt();
    check("t5_dout0", {24'd0, bus.mem_dout}, 32'hEF);
    nxt();
    check("t5_a1", bus.mem_a, 32'h101);
    check("t5_dout1", {24'd0, bus.mem_dout}, 32'hBE);
    #2;
    rst = 1'b0;
    bus.ls_req = 1'b0;
    #1;
    check("t5_async_wr", {31'd0, bus.mem_wr}, 32'd0);
    check("t5_async_busy", {31'd0, bus.busy}, 32'd0);
    check("t5_async_a", bus.mem_a, 32'h0);
    skip(2);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      nxt();
      check("t5_no_done", {31'd0, bus.ls_done}, 32'd0);
    end
    check("t5_ram_b0", {24'd0, ram_rd(32'h100)}, 32'hEF);
    check("t5_ram_b1", {24'd0, ram_rd(32'h101)}, 32'h00);
    bus.if_addr = 32'h1000; bus.if_req = 1'b1;
    skip(5);
    check("t5_fetch_early", {31'd0, bus.if_done}, 32'd0);
    nxt();
    check("t5_fetch_done", {31'd0, bus.if_done}, 32'd1);
    check("t5_fetch_data", bus.if_data, 32'h00000513);
    bus.if_req = 1'b0;
    nxt();

    // 6: ls_len=10 load behaves as word; done stretched by rdy_in low
    bus.ls_we = 1'b0; bus.ls_len = 2'b10; bus.ls_addr = 32'h1004;
    bus.ls_req = 1'b1;
    skip(4);
    check("t6_mem_a3", bus.mem_a, 32'h1007);
    nxt();
    check("t6_early_done", {31'd0, bus.ls_done}, 32'd0);
    nxt();
    check("t6_done", {31'd0, bus.ls_done}, 32'd1);
    check("t6_rdata", bus.ls_rdata, 32'h00100093);
    bus.ls_req = 1'b0;
    bus.rdy_in = 1'b0;
    nxt();
    check("t6_stretch", {31'd0, bus.ls_done}, 32'd1);
    bus.rdy_in = 1'b1;
    nxt();
    check("t6_stretch_end", {31'd0, bus.ls_done}, 32'd0);
    check("t6_idle", {31'd0, bus.busy}, 32'd0);
    nxt();
    check("t6_no_reaccept", {31'd0, bus.busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
